bus_vote_comp: RTL and testbench
================================

BUS_VOTE_COMP -- requirements
Module: bus_vote_comp

Interface
REQ-001 Parameter N_CH, default 3: redundant input channels, legal range 2..4.
REQ-002 Parameter DW, default 64: data word width, multiple of 8, legal range 8..128.
REQ-003 Parameter WIN, default 16: collect window length in clk cycles, minimum 2.
REQ-004 Parameter FAULT_LIM, default 3: consecutive failed votes before trip, minimum 1.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 dataEn  in  N_CH  per-channel one-cycle word strobe.
REQ-008 dataIn  in  N_CH*DW  channel i word at [i*DW +: DW].
REQ-009 crcIn  in  N_CH*16  channel i transmitted CRC at [i*16 +: 16], sampled with dataEn[i].
REQ-010 order  in  1  command permitting relay closure.
REQ-011 clrFault  in  1  clears trip latch and fault counter.
REQ-012 voteData  out  DW  majority word from the last completed vote.
REQ-013 voteValid  out  1  one-cycle pulse marking vote completion.
REQ-014 voteOk  out  1  last vote reached majority.
REQ-015 chOk  out  N_CH  channels that arrived in window with correct CRC in the last vote.
REQ-016 relayCtrl  out  1  relay drive; switchCtrl  out  1  trip/changeover latch.
REQ-017 faultCnt  out  3  consecutive failed-vote count; busy  out  1  high when state is not IDLE; overrun  out  1  sticky.

Function
REQ-018 States: IDLE, COLLECT, CRC, CHECK, VOTE, DONE; DONE always returns to IDLE.
REQ-019 IDLE: any dataEn bit captures that channel's data and CRC plus its arrival flag, and moves to COLLECT with window counter = 0.
REQ-020 COLLECT: each new dataEn[i] captures channel i if not yet arrived; a repeat strobe on an arrived channel is ignored (first wins).
REQ-021 COLLECT exits to CRC when all arrival flags are set or the window counter reaches WIN-1.
REQ-022 CRC: all channels are processed in parallel, one byte per cycle, MSB byte first, for exactly DW/8 cycles.
REQ-023 CRC algorithm: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR).
REQ-024 CHECK, one cycle: chOk[i] = arrived[i] AND computed CRC equals captured crcIn[i].
REQ-025 VOTE, N_CH cycles: cycle k tests candidate k, counting chOk channels whose word equals channel k's word.
REQ-026 Majority need = floor(N_CH/2)+1 of N_CH, not of the chOk count; the lowest-index chOk candidate meeting need wins; non-chOk candidates are skipped.
REQ-027 DONE: voteValid=1, voteOk and voteData are updated; voteData keeps its old value when no majority is found.
REQ-028 With all channels strobing in the same cycle t, voteValid is high in cycle t + DW/8 + N_CH + 3.
REQ-029 Fault counter: a failed vote increments it, saturating at FAULT_LIM; a successful vote clears it to 0.
REQ-030 switchCtrl is set in the DONE cycle in which faultCnt reaches FAULT_LIM, and stays set until clrFault.
REQ-031 relayCtrl is registered in DONE as voteOk AND order AND NOT switchCtrl(next value), and is held between votes.
REQ-032 relayCtrl clears on the cycle after switchCtrl sets.
REQ-033 clrFault in the same cycle as a DONE setting the trip: clrFault wins; counter = 0, switchCtrl = 0.
REQ-034 Any dataEn while in CRC, CHECK, VOTE or DONE is dropped and sets overrun; overrun is cleared only by reset.

Reset
REQ-035 With rst=0 at a clk edge: state IDLE; all outputs, arrival flags, counters and capture registers are 0.
REQ-036 Reset mid-operation aborts the frame with no voteValid pulse; a strobe in the first cycle after reset release is accepted.

Structure
REQ-037 Shared package bus_vote_pkg holds: state enum, CRC16_POLY = 16'h1021, CRC16_INIT = 16'hFFFF, and the majority-need function.
REQ-038 One sub-module, crc16_byte: combinational next-CRC from (crc, byte), instantiated N_CH times; it holds no registers.

Verification
REQ-039 Bench instance DW=72, N_CH=3; all channels, same cycle, data 0x313233343536373839, crcIn 0x29B1 -> chOk=3'b111, voteOk=1, voteValid exactly 15 cycles after the strobe, relayCtrl=1 when order=1.
REQ-040 Same frame with channel 1 crcIn=0x0000 -> chOk=3'b101, voteOk=1, voteData equals the common word, faultCnt=0.
REQ-041 Only channels 0 and 2 strobe, with data differing in bit 0 -> COLLECT lasts WIN cycles, chOk=3'b101, voteOk=0, faultCnt=1, relayCtrl=0.
REQ-042 Three consecutive failed votes with FAULT_LIM=3 -> switchCtrl=1 in the third DONE, relayCtrl=0; one clrFault pulse -> switchCtrl=0, faultCnt=0.
REQ-043 Strobe during CRC state -> overrun=1 and the vote result is unaffected; rst=0 during VOTE -> no voteValid, all outputs 0.

Source files
------------

// File: rtl/bus_vote_pkg.sv
// Shared types and constants for the redundant-bus voting comparator.
package bus_vote_pkg;

  typedef enum logic [2:0] {IDLE, COLLECT, CRC, CHECK, VOTE, DONE} stateT;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Majority is taken against the full channel count, not just the healthy ones.
  function automatic int majorityNeed(input int nCh);
    return (nCh / 2) + 1;
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// One byte step of CRC-16/CCITT-FALSE, MSB first, purely combinational.
module crc16_byte
  import bus_vote_pkg::*;
(
  input  logic [15:0] crcCur,
  input  logic [7:0]  dataByte,
  output logic [15:0] crcNext
);

  always_comb begin
    logic [15:0] c;
    c = crcCur ^ {dataByte, 8'h00};
    for (int b = 0; b < 8; b++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
    end
    crcNext = c;
  end

endmodule

// File: rtl/bus_vote_comp.sv
// Collects redundant channel words, CRC-checks them, votes a majority word
// and drives the relay / trip latch from the vote history.
//
// state   | meaning
// IDLE    | waiting for the first channel strobe
// COLLECT | window open, capturing late channels (first strobe wins)
// CRC     | one byte per cycle through all channel CRCs in parallel
// CHECK   | compare computed CRC with transmitted CRC
// VOTE    | one candidate channel per cycle
// DONE    | publish result, update fault counter, trip latch and relay
module bus_vote_comp
  import bus_vote_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DW        = 64,
  parameter int WIN       = 16,
  parameter int FAULT_LIM = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      dataEn,
  input  logic [N_CH*DW-1:0]   dataIn,
  input  logic [N_CH*16-1:0]   crcIn,
  input  logic                 order,
  input  logic                 clrFault,
  output logic [DW-1:0]        voteData,
  output logic                 voteValid,
  output logic                 voteOk,
  output logic [N_CH-1:0]      chOk,
  output logic                 relayCtrl,
  output logic                 switchCtrl,
  output logic [2:0]           faultCnt,
  output logic                 busy,
  output logic                 overrun
);

  localparam int NB   = DW / 8;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW   = $clog2(WIN);
  localparam int IW   = (N_CH > 2) ? 2 : 1;
  localparam int NEED = majorityNeed(N_CH);

  stateT             state;
  logic [DW-1:0]     dataReg [N_CH];
  logic [15:0]       crcCap  [N_CH];
  logic [15:0]       crcReg  [N_CH];
  logic [15:0]       crcNxt  [N_CH];
  logic [7:0]        curByte [N_CH];
  logic [N_CH-1:0]   arrived;
  logic [N_CH-1:0]   chOkInt;
  logic [BW-1:0]     byteCnt;
  logic [WW-1:0]     winCnt;
  logic [IW-1:0]     voteIdx;
  logic              found;
  logic [DW-1:0]     winData;
  logic [2:0]        matchCnt;
  logic              candHit;
  logic [2:0]        faultNxt;
  logic              switchNxt;

  assign busy = (state != IDLE);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      curByte[i] = dataReg[i][8*(NB-1-int'(byteCnt)) +: 8];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : genCrc
    crc16_byte uCrc (
      .crcCur   (crcReg[g]),
      .dataByte (curByte[g]),
      .crcNext  (crcNxt[g])
    );
  end

  always_comb begin
    matchCnt = 3'd0;
    for (int j = 0; j < N_CH; j++) begin
      if (chOkInt[j] && (dataReg[j] == dataReg[voteIdx])) matchCnt = matchCnt + 3'd1;
    end
    candHit = !found && chOkInt[voteIdx] && (matchCnt >= 3'(NEED));
  end

  // clrFault beats a trip raised in the same cycle.
  always_comb begin
    faultNxt  = faultCnt;
    switchNxt = switchCtrl;
    if (clrFault) begin
      faultNxt  = 3'd0;
      switchNxt = 1'b0;
    end else if (voteOk) begin
      faultNxt = 3'd0;
    end else begin
      if (faultCnt < 3'(FAULT_LIM)) faultNxt = faultCnt + 3'd1;
      if (faultNxt == 3'(FAULT_LIM)) switchNxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      arrived    <= '0;
      chOkInt    <= '0;
      byteCnt    <= '0;
      winCnt     <= '0;
      voteIdx    <= '0;
      found      <= 1'b0;
      winData    <= '0;
      voteData   <= '0;
      voteValid  <= 1'b0;
      voteOk     <= 1'b0;
      chOk       <= '0;
      relayCtrl  <= 1'b0;
      switchCtrl <= 1'b0;
      faultCnt   <= 3'd0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dataReg[i] <= '0;
        crcCap[i]  <= '0;
        crcReg[i]  <= '0;
      end
    end else begin
      voteValid <= 1'b0;
      if ((|dataEn) && (state inside {CRC, CHECK, VOTE, DONE})) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (|dataEn) begin
            for (int i = 0; i < N_CH; i++) begin
              if (dataEn[i]) begin
                dataReg[i] <= dataIn[i*DW +: DW];
                crcCap[i]  <= crcIn[i*16 +: 16];
              end
            end
            arrived <= dataEn;
            winCnt  <= '0;
            state   <= COLLECT;
          end
        end

        COLLECT: begin
          for (int i = 0; i < N_CH; i++) begin
            if (dataEn[i] && !arrived[i]) begin
              dataReg[i] <= dataIn[i*DW +: DW];
              crcCap[i]  <= crcIn[i*16 +: 16];
              arrived[i] <= 1'b1;
            end
          end
          if ((&arrived) || (winCnt == WW'(WIN-1))) begin
            byteCnt <= '0;
            for (int i = 0; i < N_CH; i++) crcReg[i] <= CRC16_INIT;
            state <= CRC;
          end else begin
            winCnt <= winCnt + 1'b1;
          end
        end

        CRC: begin
          for (int i = 0; i < N_CH; i++) crcReg[i] <= crcNxt[i];
          if (byteCnt == BW'(NB-1)) state <= CHECK;
          else                      byteCnt <= byteCnt + 1'b1;
        end

        CHECK: begin
          for (int i = 0; i < N_CH; i++) chOkInt[i] <= arrived[i] && (crcReg[i] == crcCap[i]);
          voteIdx <= '0;
          found   <= 1'b0;
          state   <= VOTE;
        end

        VOTE: begin
          if (candHit) begin
            found   <= 1'b1;
            winData <= dataReg[voteIdx];
          end
          if (voteIdx == IW'(N_CH-1)) begin
            voteValid <= 1'b1;
            voteOk    <= found || candHit;
            chOk      <= chOkInt;
            if (found)        voteData <= winData;
            else if (candHit) voteData <= dataReg[voteIdx];
            state <= DONE;
          end else begin
            voteIdx <= voteIdx + 1'b1;
          end
        end

        DONE: begin
          faultCnt   <= faultNxt;
          switchCtrl <= switchNxt;
          relayCtrl  <= voteOk && order && !switchNxt;
          arrived    <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if ((state != DONE) && clrFault) begin
        faultCnt   <= 3'd0;
        switchCtrl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_vote_comp.sv
// Directed bench for bus_vote_comp with N_CH=3, DW=72, WIN=16, FAULT_LIM=3.
module tb_bus_vote_comp;

  localparam int N_CH = 3;
  localparam int DW   = 72;
  localparam logic [71:0] W0 = 72'h313233343536373839;
  localparam logic [71:0] W1 = 72'h313233343536373838;
  localparam logic [15:0] C0 = 16'h29B1;

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   dataEn;
  logic [N_CH*DW-1:0] dataIn;
  logic [N_CH*16-1:0] crcIn;
  logic              order;
  logic              clrFault;
  logic [DW-1:0]     voteData;
  logic              voteValid;
  logic              voteOk;
  logic [N_CH-1:0]   chOk;
  logic              relayCtrl;
  logic              switchCtrl;
  logic [2:0]        faultCnt;
  logic              busy;
  logic              overrun;

  int testsRun = 0;
  int failCnt  = 0;
  int lat;
  logic [15:0] c1;

  bus_vote_comp #(.N_CH(N_CH), .DW(DW), .WIN(16), .FAULT_LIM(3)) dut (
    .clk(clk), .rst(rst), .dataEn(dataEn), .dataIn(dataIn), .crcIn(crcIn),
    .order(order), .clrFault(clrFault), .voteData(voteData), .voteValid(voteValid),
    .voteOk(voteOk), .chOk(chOk), .relayCtrl(relayCtrl), .switchCtrl(switchCtrl),
    .faultCnt(faultCnt), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference CRC-16/CCITT-FALSE over a 72-bit word, MSB first.
  function automatic logic [15:0] crcRef(input logic [71:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 71; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [71:0] d0, input logic [71:0] d1,
                       input logic [71:0] d2, input logic [15:0] k0, input logic [15:0] k1,
                       input logic [15:0] k2);
    dataIn = {d2, d1, d0};
    crcIn  = {k2, k1, k0};
    dataEn = en;
  endtask

  task automatic sendFrame(input logic [2:0] en, input logic [71:0] d0, input logic [71:0] d1,
                           input logic [71:0] d2, input logic [15:0] k0, input logic [15:0] k1,
                           input logic [15:0] k2);
    @(negedge clk);
    drive(en, d0, d1, d2, k0, k1, k2);
  endtask

  // Counts cycles from the strobe cycle to the voteValid cycle; -1 on timeout.
  task automatic waitVote(output int latency);
    latency = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      dataEn = '0;
      if (voteValid === 1'b1) begin
        latency = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; dataEn = '0; dataIn = '0; crcIn = '0; order = 1'b1; clrFault = 1'b0;
    c1 = crcRef(W1);
    repeat (3) @(negedge clk);
    check("reset_outputs", {voteData, voteValid, voteOk, chOk, relayCtrl, switchCtrl, faultCnt, busy, overrun}, '0);
    rst = 1'b1;

    // Clean frame on all three channels.
    sendFrame(3'b111, W0, W0, W0, C0, C0, C0);
    waitVote(lat);
    check("a_latency", lat, 15);
    check("a_chOk", chOk, 3'b111);
    check("a_voteOk", voteOk, 1'b1);
    check("a_voteData", voteData, W0);
    @(negedge clk);
    check("a_relay", relayCtrl, 1'b1);
    check("a_fault", {switchCtrl, faultCnt}, 4'b0_000);
    check("a_idle", {busy, overrun}, 2'b00);

    // Channel 1 CRC corrupted; two good channels still form a majority.
    order = 1'b0;
    sendFrame(3'b111, W0, W0, W0, C0, 16'h0000, C0);
    waitVote(lat);
    check("b_latency", lat, 15);
    check("b_chOk", chOk, 3'b101);
    check("b_voteOk", voteOk, 1'b1);
    check("b_voteData", voteData, W0);
    @(negedge clk);
    check("b_faultCnt", faultCnt, 3'd0);
    check("b_relay_order0", relayCtrl, 1'b0);
    order = 1'b1;

    // Channel 1 silent, 0 and 2 disagree: window timeout, failed vote.
    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    check("c_latency", lat, 30);
    check("c_chOk", chOk, 3'b101);
    check("c_voteOk", voteOk, 1'b0);
    check("c_voteData_kept", voteData, W0);
    @(negedge clk);
    check("c_faultCnt", faultCnt, 3'd1);
    check("c_relay", relayCtrl, 1'b0);
    check("c_switch", switchCtrl, 1'b0);

    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    @(negedge clk);
    check("d_fault", {switchCtrl, faultCnt}, 4'b0_010);

    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    @(negedge clk);
    check("e_trip", {switchCtrl, faultCnt}, 4'b1_011);
    check("e_relay", relayCtrl, 1'b0);

    @(negedge clk); clrFault = 1'b1;
    @(negedge clk); clrFault = 1'b0;
    check("clr_fault", {switchCtrl, faultCnt}, 4'b0_000);

    // Two failures, then clrFault coincides with the tripping DONE.
    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    @(negedge clk);
    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    @(negedge clk);
    check("f_fault2", faultCnt, 3'd2);
    sendFrame(3'b101, W0, W0, W1, C0, C0, c1);
    waitVote(lat);
    clrFault = 1'b1;
    @(negedge clk);
    clrFault = 1'b0;
    check("f_clr_wins", {switchCtrl, faultCnt}, 4'b0_000);

    sendFrame(3'b111, W0, W0, W0, C0, C0, C0);
    waitVote(lat);
    @(negedge clk);
    check("g_relay_back", relayCtrl, 1'b1);

    // Strobe during CRC is dropped and flagged.
    sendFrame(3'b111, W0, W0, W0, C0, C0, C0);
    @(negedge clk); dataEn = '0;
    @(negedge clk);
    drive(3'b111, 72'hDEADBEEF00, 72'h5A5A, 72'h1, 16'h1234, 16'h1234, 16'h1234);
    check("h_busy", busy, 1'b1);
    @(negedge clk); dataEn = '0;
    waitVote(lat);
    check("h_latency", lat, 12);
    check("h_result", {chOk, voteOk, voteData}, {3'b111, 1'b1, W0});
    check("h_overrun", overrun, 1'b1);

    // Reset during VOTE aborts the frame; strobe right at release is taken.
    @(negedge clk);
    sendFrame(3'b111, W0, W0, W0, C0, C0, C0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      dataEn = '0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("r_outputs", {voteData, voteValid, voteOk, chOk, relayCtrl, switchCtrl, faultCnt, busy, overrun}, '0);
    rst = 1'b1;
    drive(3'b111, W0, W0, W0, C0, C0, C0);
    waitVote(lat);
    check("r_no_stale_vote", lat, 15);
    check("r_result", {chOk, voteOk, voteData}, {3'b111, 1'b1, W0});

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
